// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port word RAM, one access per 3 cycles.
// Define RAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (m0 wins).
module ram_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m0_req,
    input  logic                     m0_we,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    output logic                     m0_ready,
    output logic                     m0_rvalid,
    output logic [DATA_WIDTH-1:0]    m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_we,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    output logic                     m1_ready,
    output logic                     m1_rvalid,
    output logic [DATA_WIDTH-1:0]    m1_rdata,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t                   state_q, state_d;
    logic                     we_q, we_d, id_q, id_d, win;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d, m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic                     last_q, last_d;
    assign win = (m0_req && m1_req) ? ~last_q : m1_req;
`else
    assign win = !m0_req;
`endif
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        id_d       = id_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        m0_ready   = 1'b0;
        m1_ready   = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        ram_we     = 1'b0;
        if (state_q == IDLE && (m0_req || m1_req) && !rst) begin
            state_d  = ACCESS;
            id_d     = win;
            we_d     = win ? m1_we : m0_we;
            addr_d   = win ? m1_addr : m0_addr;
            wdata_d  = win ? m1_wdata : m0_wdata;
            m0_ready = !win;
            m1_ready = win;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_d   = win;
`endif
        end
        if (state_q == ACCESS) begin
            state_d    = RESP;
            ram_we     = we_q;
            m0_rdata_d = id_q ? m0_rdata_q : (we_q ? '0 : ram_rdata);
            m1_rdata_d = id_q ? (we_q ? '0 : ram_rdata) : m1_rdata_q;
        end
        // A reset landing in RESP abandons the completion, so the pulse is suppressed.
        if (state_q == RESP) begin
            state_d   = IDLE;
            m0_rvalid = !rst && !id_q;
            m1_rvalid = !rst && id_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            id_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of ram_arbiter against a small word RAM model.
module tb_ram_arbiter;
    logic        clk = 1'b0, rst;
    logic        m0_req, m0_we, m0_ready, m0_rvalid, m1_req, m1_we, m1_ready, m1_rvalid, ram_we;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [31:0] mem [16];
    int          total = 0, bad = 0;
    logic        exp_id;

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    assign ram_rdata = mem[ram_addr[5:2]];
    always @(posedge clk) if (ram_we) mem[ram_addr[5:2]] <= ram_wdata;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        rst = 1'b1;
        {m0_req, m0_we, m1_req, m1_we} = 4'b0;
        {m0_addr, m0_wdata, m1_addr, m1_wdata} = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk32("rst_m0_rdata", m0_rdata, 32'h0);
        chk32("rst_m1_rdata", m1_rdata, 32'h0);
        chk1("rst_ram_we", ram_we, 1'b0);
        chk32("rst_ram_addr", ram_addr, 32'h0);
        chk32("rst_ram_wdata", ram_wdata, 32'h0);
        chk1("rst_rvalid", m0_rvalid | m1_rvalid, 1'b0);

        // single read by m0
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10000;
        #1;
        chk1("rd_m0_ready", m0_ready, 1'b1);
        chk1("rd_m1_ready", m1_ready, 1'b0);
        step();
        m0_req = 1'b0;
        #1;
        chk1("rd_acc_ready", m0_ready, 1'b0);
        chk1("rd_acc_we", ram_we, 1'b0);
        chk32("rd_acc_addr", ram_addr, 32'h10000);
        step();
        chk1("rd_resp_rvalid0", m0_rvalid, 1'b1);
        chk1("rd_resp_rvalid1", m1_rvalid, 1'b0);
        chk32("rd_resp_rdata", m0_rdata, 32'h11223344);
        chk32("rd_resp_addr_hold", ram_addr, 32'h10000);
        step();
        chk1("rd_idle_rvalid0", m0_rvalid, 1'b0);
        chk32("rd_idle_rdata_hold", m0_rdata, 32'h11223344);

        // m1 write then read back
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10004; m1_wdata = 32'hDEADBEEF;
        #1;
        chk1("wr_m1_ready", m1_ready, 1'b1);
        chk1("wr_m0_ready", m0_ready, 1'b0);
        chk1("wr_idle_we", ram_we, 1'b0);
        step();
        m1_req = 1'b0;
        #1;
        chk1("wr_acc_we", ram_we, 1'b1);
        chk32("wr_acc_addr", ram_addr, 32'h10004);
        chk32("wr_acc_wdata", ram_wdata, 32'hDEADBEEF);
        step();
        chk1("wr_resp_we", ram_we, 1'b0);
        chk1("wr_resp_rvalid1", m1_rvalid, 1'b1);
        chk1("wr_resp_rvalid0", m0_rvalid, 1'b0);
        chk32("wr_resp_rdata", m1_rdata, 32'h0);
        step();
        m1_req = 1'b1; m1_we = 1'b0;
        #1;
        chk1("rb_m1_ready", m1_ready, 1'b1);
        step();
        m1_req = 1'b0;
        step();
        chk1("rb_rvalid1", m1_rvalid, 1'b1);
        chk32("rb_rdata", m1_rdata, 32'hDEADBEEF);
        chk32("rb_m0_rdata_hold", m0_rdata, 32'h11223344);
        step();

        // contention: both held for four transactions
        m0_req = 1'b1; m0_addr = 32'h10000;
        m1_req = 1'b1; m1_addr = 32'h10004;
        #1;
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
            exp_id = (k % 2) == 1;
`else
            exp_id = 1'b0;
`endif
            chk1("cont_ready0", m0_ready, !exp_id);
            chk1("cont_ready1", m1_ready, exp_id);
            step();
            chk1("cont_acc_noready", m0_ready | m1_ready, 1'b0);
            step();
            chk1("cont_rvalid0", m0_rvalid, !exp_id);
            chk1("cont_rvalid1", m1_rvalid, exp_id);
            chk1("cont_resp_noready", m0_ready | m1_ready, 1'b0);
            step();
        end

        // back-to-back: m0 alone, ready every third cycle
        m1_req = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) begin
            chk1("b2b_ready0", m0_ready, (i % 3) == 0);
            step();
        end
        m0_req = 1'b0;

        // reset during RESP of an m0 read
        m0_req = 1'b1; m0_addr = 32'h10004;
        #1;
        chk1("mr_ready0", m0_ready, 1'b1);
        step();
        m0_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk1("mr_no_rvalid", m0_rvalid, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk1("mr_post_rvalid", m0_rvalid, 1'b0);
        chk32("mr_rdata_cleared", m0_rdata, 32'h0);
        chk32("mr_addr_cleared", ram_addr, 32'h0);
        m0_req = 1'b1; m0_addr = 32'h10000;
        #1;
        chk1("mr_next_ready", m0_ready, 1'b1);
        step();
        m0_req = 1'b0;
        step();
        chk1("mr_next_rvalid", m0_rvalid, 1'b1);
        chk32("mr_next_rdata", m0_rdata, 32'h11223344);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter: ADDRESS_WIDTH, 32, byte address width on all ports.
REQ-002 SHALL have parameter: DATA_WIDTH, 32, access data width; fixed 32 for the word-wide RAM port.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports, per requester n in {0,1}:
- mn_req  input  1  access request.
- mn_we  input  1  1=write, 0=read.
- mn_addr  input  ADDRESS_WIDTH  byte address.
- mn_wdata  input  DATA_WIDTH  write data.
- mn_ready  output  1  request accepted this cycle.
- mn_rvalid  output  1  one-cycle completion pulse.
- mn_rdata  output  DATA_WIDTH  read data, valid with mn_rvalid.
REQ-006 SHALL have RAM-side ports:
- ram_we  output  1  write enable.
- ram_addr  output  ADDRESS_WIDTH  RAM address.
- ram_wdata  output  DATA_WIDTH  RAM write data.
- ram_rdata  input  DATA_WIDTH  combinational RAM read data.

Function
REQ-007 SHALL implement a three-state FSM:
- IDLE -> ACCESS when any mn_req=1.
- ACCESS -> RESP unconditionally.
- RESP -> IDLE unconditionally.
REQ-008 In IDLE, SHALL assert mn_ready combinationally, for exactly one winner, when at least one mn_req=1; ready SHALL be 0 in ACCESS and RESP.
REQ-009 On acceptance, SHALL latch the winner's we, addr, wdata and id into internal registers; requesters need hold signals only until ready.
REQ-010 In ACCESS, SHALL drive ram_addr/ram_wdata from the latched values and ram_we=latched we for exactly that one cycle.
REQ-011 On the ACCESS->RESP edge, SHALL capture ram_rdata into the winner's rdata register; for writes, the captured value SHALL be 0.
REQ-012 In RESP, SHALL assert the winner's rvalid for exactly one cycle; the other requester's rvalid SHALL stay 0.
REQ-013 Latency SHALL be: accept in cycle N, RAM access in N+1, rvalid in N+2; next acceptance no earlier than N+3.
REQ-014 ram_we SHALL be 0 in every state except ACCESS of a write.
REQ-015 Outside ACCESS, ram_addr and ram_wdata SHALL hold their last latched values.
REQ-016 SHALL pass addresses unaltered; no alignment check, and the RAM handles byte lanes.
REQ-017 Simultaneous requests SHALL be resolved per REQ-022/023.
REQ-018 A request arriving in ACCESS or RESP SHALL wait, unacknowledged, until IDLE.
REQ-019 mn_rdata SHALL hold its value until that requester's next completion.

Reset
REQ-020 With rst=1 at a rising edge, the block SHALL enter IDLE with the following values:
- last-grant pointer=1, so requester 0 wins first.
- latched we=0, addr=0, wdata=0.
- m0_rdata=m1_rdata=0.
REQ-021 Reset asserted in ACCESS or RESP SHALL abandon the access:
- no rvalid is produced.
- ram_we is 0 from the cycle after the reset edge.
- the RAM write SHALL occur only if ACCESS was already the current state at that edge.

Configuration
REQ-022 With macro RAM_ARB_ROUND_ROBIN_EN defined, the winner SHALL be chosen by round-robin:
- on simultaneous requests, the requester not granted last wins.
- the last-grant pointer updates on each acceptance.
REQ-023 Without RAM_ARB_ROUND_ROBIN_EN, priority SHALL be fixed: m0 always wins over m1, and the pointer SHALL be absent.

Verification
REQ-024 Single read: RAM[0x10000..3]=0x11223344, m0 read 0x10000 -> m0_ready at N, ram_we=0 at N+1, m0_rvalid=1 and m0_rdata=0x11223344 at N+2.
REQ-025 Write then read: m1 write 0x10004 data 0xDEADBEEF -> ram_we=1 only at N+1 and m1_rvalid at N+2 with rdata=0; subsequent m1 read 0x10004 -> rdata=0xDEADBEEF.
REQ-026 Contention: m0 and m1 both held requesting for 4 transactions -> with RAM_ARB_ROUND_ROBIN_EN, grants 0,1,0,1; without it, grants 0,0,0,0 with m1 starved.
REQ-027 Back-to-back: m0 request held continuously -> ready pulses every 3 cycles, and no ready in ACCESS/RESP.
REQ-028 Reset mid-op: rst=1 during RESP of an m0 read -> no m0_rvalid, FSM returns to IDLE, m0_rdata=0, next request accepted normally.
